// File: rtl/id_operand_if.sv
// ============================================================================
// id_operand_if : IF/regfile/forwarding/EX bundle around the decode operand stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface id_operand_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 3,
  parameter int PC_W    = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic [PC_W-1:0]           in_pc;
  logic [31:0]               in_inst;
  logic                      flush;
  logic [ADDR_W-1:0]         rs_addr;
  logic [ADDR_W-1:0]         rt_addr;
  logic [DATA_W-1:0]         rf_rdata1;
  logic [DATA_W-1:0]         rf_rdata2;
  logic [NUM_FWD-1:0]        fwd_we;
  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr;
  logic [NUM_FWD*DATA_W-1:0] fwd_wdata;
  logic [NUM_FWD-1:0]        fwd_pending;
  logic                      out_valid;
  logic                      out_ready;
  logic [PC_W-1:0]           out_pc;
  logic [31:0]               out_inst;
  logic [DATA_W-1:0]         out_src1;
  logic [DATA_W-1:0]         out_src2;
  logic                      stall_req;

  // master is the operand stage itself; slave is the surrounding pipeline
  modport master (
    input  in_valid, in_pc, in_inst, flush, rf_rdata1, rf_rdata2,
           fwd_we, fwd_waddr, fwd_wdata, fwd_pending, out_ready,
    output in_ready, rs_addr, rt_addr, out_valid, out_pc, out_inst,
           out_src1, out_src2, stall_req
  );

  modport slave (
    output in_valid, in_pc, in_inst, flush, rf_rdata1, rf_rdata2,
           fwd_we, fwd_waddr, fwd_wdata, fwd_pending, out_ready,
    input  in_ready, rs_addr, rt_addr, out_valid, out_pc, out_inst,
           out_src1, out_src2, stall_req
  );
endinterface

`default_nettype wire

// File: rtl/id_operand_stage.sv
// ============================================================================
// id_operand_stage : decode holding register with N-source forwarding and load-use
// interlock. Optional perf counters under ID_PERF_CNT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module id_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_FWD = 3,
  parameter int PC_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  id_operand_if.master      bus
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_fwd_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;

  logic [ADDR_W-1:0] rs_addr, rt_addr;
  logic [DATA_W-1:0] src1, src2;
  logic              hit1, hit2, haz1, haz2;
  logic              hazard, out_valid, out_fire, in_ready, in_fire;

  assign rs_addr = ADDR_W'(inst_q[25:21]);
  assign rt_addr = ADDR_W'(inst_q[20:16]);

  // Walk oldest to youngest so the lowest matching index ends up winning.
  always_comb begin
    src1 = bus.rf_rdata1;
    src2 = bus.rf_rdata2;
    hit1 = 1'b0;
    hit2 = 1'b0;
    haz1 = 1'b0;
    haz2 = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (bus.fwd_we[i] && (bus.fwd_waddr[i*ADDR_W +: ADDR_W] == rs_addr)) begin
        src1 = bus.fwd_wdata[i*DATA_W +: DATA_W];
        hit1 = 1'b1;
        haz1 = bus.fwd_pending[i];
      end
      if (bus.fwd_we[i] && (bus.fwd_waddr[i*ADDR_W +: ADDR_W] == rt_addr)) begin
        src2 = bus.fwd_wdata[i*DATA_W +: DATA_W];
        hit2 = 1'b1;
        haz2 = bus.fwd_pending[i];
      end
    end
    if (rs_addr == '0) begin
      src1 = '0;
      hit1 = 1'b0;
      haz1 = 1'b0;
    end
    if (rt_addr == '0) begin
      src2 = '0;
      hit2 = 1'b0;
      haz2 = 1'b0;
    end
  end

  assign hazard    = (state_q != ST_EMPTY) && (haz1 || haz2);
  assign out_valid = (state_q != ST_EMPTY) && !hazard && !bus.flush;
  assign out_fire  = out_valid && bus.out_ready;
  assign in_ready  = (state_q == ST_EMPTY) || out_fire;
  assign in_fire   = bus.in_valid && in_ready && !bus.flush;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else if (in_fire) begin
      state_d = ST_FULL;
      pc_d    = bus.in_pc;
      inst_d  = bus.in_inst;
    end else if (out_fire) begin
      state_d = ST_EMPTY;
    end else if (hazard) begin
      state_d = ST_STALL;
    end else if (state_q == ST_STALL) begin
      state_d = ST_FULL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.rs_addr   = rs_addr;
  assign bus.rt_addr   = rt_addr;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = pc_q;
  assign bus.out_inst  = inst_q;
  assign bus.out_src1  = src1;
  assign bus.out_src2  = src2;
  assign bus.stall_req = hazard;

`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (hazard && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (out_fire && (hit1 || hit2) && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
      fwd_cnt_d = fwd_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_fwd_cnt   = fwd_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_operand_stage.sv
// ============================================================================
// tb_id_operand_stage : directed bench for id_operand_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_id_operand_stage;

  localparam logic [31:0] INST_A = 32'h0022_1821; // addu $3,$1,$2
  localparam logic [31:0] INST_B = 32'h0002_2021; // addu $4,$0,$2
  localparam logic [31:0] INST_C = 32'h0043_2821; // addu $5,$2,$3
  localparam logic [31:0] INST_D = 32'h0085_3021; // addu $6,$4,$5

  logic clk;
  logic rst;
  int   total;
  int   bad;

  id_operand_if #(.DATA_W(32), .ADDR_W(5), .NUM_FWD(3), .PC_W(32)) bus ();

`ifdef ID_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_fwd_cnt;
  id_operand_stage #(.DATA_W(32), .ADDR_W(5), .NUM_FWD(3), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
  );
`else
  id_operand_stage #(.DATA_W(32), .ADDR_W(5), .NUM_FWD(3), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_fwd();
    bus.fwd_we      = '0;
    bus.fwd_waddr   = '0;
    bus.fwd_wdata   = '0;
    bus.fwd_pending = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall_req got=%b want=0", bus.stall_req); end
    total++; if (bus.out_pc !== 32'h0) begin bad++; $display("FAIL reset_out_pc got=%h want=0", bus.out_pc); end
    total++; if (bus.out_inst !== 32'h0) begin bad++; $display("FAIL reset_out_inst got=%h want=0", bus.out_inst); end
    total++; if (bus.out_src1 !== 32'h0 || bus.out_src2 !== 32'h0) begin bad++; $display("FAIL reset_src got=%h/%h want=0/0", bus.out_src1, bus.out_src2); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h100;
    bus.in_inst   = INST_A;
    bus.rf_rdata1 = 32'd5;
    bus.rf_rdata2 = 32'd7;
    bus.out_ready = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_empty_ready got=%b want=1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%b want=1", bus.out_valid); end
    total++; if (bus.out_src1 !== 32'd5) begin bad++; $display("FAIL basic_src1 got=%h want=5", bus.out_src1); end
    total++; if (bus.out_src2 !== 32'd7) begin bad++; $display("FAIL basic_src2 got=%h want=7", bus.out_src2); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.rs_addr !== 5'd1 || bus.rt_addr !== 5'd2) begin bad++; $display("FAIL basic_addr got=%0d/%0d want=1/2", bus.rs_addr, bus.rt_addr); end
    total++; if (bus.out_pc !== 32'h100) begin bad++; $display("FAIL basic_pc got=%h want=100", bus.out_pc); end
    bus.out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fwd_priority();
    bus.fwd_we    = 3'b101;
    bus.fwd_waddr = {5'd1, 5'd0, 5'd1};
    bus.fwd_wdata = {32'hBB, 32'h0, 32'hAA};
    #1;
    total++; if (bus.out_src1 !== 32'hAA) begin bad++; $display("FAIL fwd_youngest got=%h want=aa", bus.out_src1); end
    total++; if (bus.out_src2 !== 32'd7) begin bad++; $display("FAIL fwd_src2_rf got=%h want=7", bus.out_src2); end
    bus.fwd_we = 3'b100;
    #1;
    total++; if (bus.out_src1 !== 32'hBB) begin bad++; $display("FAIL fwd_oldest got=%h want=bb", bus.out_src1); end
    bus.fwd_we    = 3'b010;
    bus.fwd_waddr = {5'd0, 5'd2, 5'd0};
    bus.fwd_wdata = {32'h0, 32'hCC, 32'h0};
    #1;
    total++; if (bus.out_src2 !== 32'hCC || bus.out_src1 !== 32'd5) begin bad++; $display("FAIL fwd_rt got=%h/%h want=5/cc", bus.out_src1, bus.out_src2); end
    clear_fwd();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h104;
    bus.in_inst   = INST_B;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b want=1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    total++; if (bus.out_inst !== INST_B || bus.out_pc !== 32'h104 || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_replace got=%h/%h/%b want=%h/104/1", bus.out_inst, bus.out_pc, bus.out_valid, INST_B);
    end
    bus.fwd_we    = 3'b001;
    bus.fwd_waddr = {5'd0, 5'd0, 5'd0};
    bus.fwd_wdata = {32'h0, 32'h0, 32'hCC};
    bus.rf_rdata1 = 32'h55;
    #1;
    total++; if (bus.out_src1 !== 32'h0) begin bad++; $display("FAIL zero_reg got=%h want=0", bus.out_src1); end
    clear_fwd();
    bus.rf_rdata1 = 32'd5;
  endtask

  task automatic test_load_use();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h108;
    bus.in_inst   = INST_A;
    @(negedge clk);
    bus.fwd_we      = 3'b001;
    bus.fwd_waddr   = {5'd0, 5'd0, 5'd1};
    bus.fwd_wdata   = {32'h0, 32'h0, 32'h77};
    bus.fwd_pending = 3'b001;
    bus.in_inst     = INST_C;
    bus.in_pc       = 32'h10C;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.stall_req !== 1'b1 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL lu_detect got=v%b s%b r%b want=v0 s1 r0", bus.out_valid, bus.stall_req, bus.in_ready);
    end
    @(negedge clk);
    #1;
    total++; if (bus.stall_req !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_inst !== INST_A) begin
      bad++; $display("FAIL lu_hold got=s%b r%b inst=%h want=s1 r0 %h", bus.stall_req, bus.in_ready, bus.out_inst, INST_A);
    end
    bus.in_valid    = 1'b0;
    bus.fwd_pending = 3'b000;
    bus.fwd_wdata   = {32'h0, 32'h0, 32'h9};
    #1;
    total++; if (bus.out_valid !== 1'b1 || bus.out_src1 !== 32'h9 || bus.stall_req !== 1'b0) begin
      bad++; $display("FAIL lu_release got=v%b src1=%h s%b want=v1 9 s0", bus.out_valid, bus.out_src1, bus.stall_req);
    end
    bus.fwd_we      = 3'b101;
    bus.fwd_waddr   = {5'd1, 5'd0, 5'd1};
    bus.fwd_pending = 3'b100;
    #1;
    total++; if (bus.out_valid !== 1'b1 || bus.out_src1 !== 32'h9) begin
      bad++; $display("FAIL lu_shadowed_pending got=v%b src1=%h want=v1 9", bus.out_valid, bus.out_src1);
    end
    bus.out_ready = 1'b0;
    clear_fwd();
    @(negedge clk);
  endtask

  task automatic test_hold();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h10C;
    bus.in_inst   = INST_C;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (bus.in_ready !== 1'b0 || bus.out_inst !== INST_A || bus.out_pc !== 32'h108) begin
        bad++; $display("FAIL hold_%0d got=r%b %h/%h want=r0 %h/108", k, bus.in_ready, bus.out_inst, bus.out_pc, INST_A);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL hold_release_ready got=%b want=1", bus.in_ready); end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    total++; if (bus.out_inst !== INST_C || bus.out_pc !== 32'h10C || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL hold_reload got=%h/%h/%b want=%h/10c/1", bus.out_inst, bus.out_pc, bus.out_valid, INST_C);
    end
  endtask

  task automatic test_flush();
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 32'h110;
    bus.in_inst   = INST_D;
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL flush_mask got=v%b r%b want=v0 r0", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_inst !== INST_C) begin
      bad++; $display("FAIL flush_empty got=v%b r%b inst=%h want=v0 r1 %h", bus.out_valid, bus.in_ready, bus.out_inst, INST_C);
    end
  endtask

  task automatic test_reset_stall();
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h200;
    bus.in_inst  = INST_A;
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    bus.fwd_we      = 3'b001;
    bus.fwd_waddr   = {5'd0, 5'd0, 5'd1};
    bus.fwd_pending = 3'b001;
    @(negedge clk);
    #1;
    total++; if (bus.stall_req !== 1'b1) begin bad++; $display("FAIL rststall_pre got=%b want=1", bus.stall_req); end
    rst = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.stall_req !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL rststall_drop got=v%b s%b r%b want=v0 s0 r1", bus.out_valid, bus.stall_req, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b0;
    clear_fwd();
  endtask

`ifdef ID_PERF_CNT_EN
  task automatic test_perf();
    #1;
    total++; if (perf_stall_cnt !== 32'd0 || perf_fwd_cnt !== 32'd0) begin
      bad++; $display("FAIL perf_reset got=%0d/%0d want=0/0", perf_stall_cnt, perf_fwd_cnt);
    end
    bus.in_valid = 1'b1;
    bus.in_pc    = 32'h300;
    bus.in_inst  = INST_A;
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    bus.fwd_we      = 3'b001;
    bus.fwd_waddr   = {5'd0, 5'd0, 5'd1};
    bus.fwd_wdata   = {32'h0, 32'h0, 32'h9};
    bus.fwd_pending = 3'b001;
    repeat (4) @(negedge clk);
    bus.fwd_pending = 3'b000;
    @(negedge clk);
    bus.out_ready = 1'b0;
    clear_fwd();
    #1;
    total++; if (perf_stall_cnt !== 32'd4 || perf_fwd_cnt !== 32'd1) begin
      bad++; $display("FAIL perf_counts got=%0d/%0d want=4/1", perf_stall_cnt, perf_fwd_cnt);
    end
  endtask
`endif

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_inst   = '0;
    bus.flush     = 1'b0;
    bus.rf_rdata1 = '0;
    bus.rf_rdata2 = '0;
    bus.out_ready = 1'b0;
    clear_fwd();
    @(negedge clk);
    test_reset();
    test_basic();
    test_fwd_priority();
    test_back_to_back();
    test_load_use();
    test_hold();
    test_flush();
    test_reset_stall();
`ifdef ID_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
